// File: rtl/hamming_stream_decoder_if.sv
// Codeword-in / message-out stream bundle for the (7,4) Hamming decoder, plus statistics.
// master drives codewords and output ready; slave is the decoder.
interface hamming_stream_decoder_if #(
   parameter int CNT_W = 16
);
   logic [6:0]       c_in;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       u_out;
   logic [2:0]       syn_out;
   logic             err_out;
   logic             out_valid;
   logic             out_ready;
   logic             stat_clr;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] corr_cnt;

   modport master (
      output c_in, in_valid, out_ready, stat_clr,
      input  in_ready, u_out, syn_out, err_out, out_valid, word_cnt, corr_cnt
   );

   modport slave (
      input  c_in, in_valid, out_ready, stat_clr,
      output in_ready, u_out, syn_out, err_out, out_valid, word_cnt, corr_cnt
   );
endinterface

// File: rtl/hamming_stream_decoder.sv
// Streaming (7,4) Hamming single-error corrector, 2-stage valid/ready pipeline (2 cycles, 1 word/cycle).
// Optional saturating word/correction counters when HAMMING_DEC_STATS_EN is defined.
module hamming_stream_decoder #(
   parameter int CNT_W = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   hamming_stream_decoder_if.slave bus
);
   logic       s1_valid;
   logic [6:0] s1_c;
   logic [2:0] s1_syn;
   logic       s2_valid;
   logic [3:0] s2_u;
   logic [2:0] s2_syn;
   logic       s2_err;

   logic       s1_adv;
   logic       s2_adv;
   logic       out_fire;
   logic [2:0] in_syn;
   logic [6:0] flip;
   logic [6:0] fixed;

   function automatic logic [2:0] syndrome(input logic [6:0] c);
      return {c[3] ^ c[4] ^ c[5] ^ c[6],
              c[1] ^ c[2] ^ c[5] ^ c[6],
              c[0] ^ c[2] ^ c[4] ^ c[6]};
   endfunction

   // in_ready depends combinationally on out_ready so a full pipeline streams without bubbles.
   assign s2_adv       = !s2_valid || bus.out_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv;
   assign out_fire     = s2_valid && bus.out_ready;
   assign in_syn       = syndrome(bus.c_in);

   always_comb begin
      flip = '0;
      if (s1_syn != 3'd0) begin
         flip[s1_syn - 3'd1] = 1'b1;
      end
   end

   assign fixed = s1_c ^ flip;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_c     <= '0;
         s1_syn   <= '0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_c   <= bus.c_in;
            s1_syn <= in_syn;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_u     <= '0;
         s2_syn   <= '0;
         s2_err   <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_u   <= {fixed[6], fixed[5], fixed[4], fixed[2]};
            s2_syn <= s1_syn;
            s2_err <= |s1_syn;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.u_out     = s2_u;
   assign bus.syn_out   = s2_syn;
   assign bus.err_out   = s2_err;

`ifdef HAMMING_DEC_STATS_EN
   logic [CNT_W-1:0] word_q;
   logic [CNT_W-1:0] corr_q;

   // Clear wins over a same-cycle increment; both counters stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         corr_q <= '0;
      end else if (bus.stat_clr) begin
         word_q <= '0;
         corr_q <= '0;
      end else if (out_fire) begin
         if (word_q != '1) begin
            word_q <= word_q + 1'b1;
         end
         if (s2_err && (corr_q != '1)) begin
            corr_q <= corr_q + 1'b1;
         end
      end
   end

   assign bus.word_cnt = word_q;
   assign bus.corr_cnt = corr_q;
`else
   logic [CNT_W-1:0] cnt_zero;
   logic             unused_stats;

   assign cnt_zero     = '0;
   assign bus.word_cnt = cnt_zero;
   assign bus.corr_cnt = cnt_zero;
   assign unused_stats = bus.stat_clr ^ out_fire;
`endif
endmodule
